// File: rtl/mem_request_arbiter.sv
// Round-robin arbiter merging PORTS request channels onto one memory port,
// with optional burst locking and id-tagged response routing back to ports.
//
// Ports (flattened channel bundles, index p = requester):
//   clk, rst                  clock and synchronous active-high reset
//   req_in_*  [PORTS]         requester request channels (valid/ready, payload)
//   req_out_*                 merged registered request, id = {port, req id}
//   rsp_in_*                  memory responses, id upper bits select the port
//   rsp_out_* [PORTS]         per-requester registered responses
module mem_request_arbiter #(
   parameter  int PORTS        = 2,
   parameter  int DATA_WIDTH   = 32,
   parameter  int ADDR_WIDTH   = 10,
   parameter  int ID_WIDTH     = 1,
   parameter  int LOCK_ON_LAST = 1,
   localparam int PORT_BITS    = (PORTS > 1) ? $clog2(PORTS) : 1,
   localparam int OUT_ID_WIDTH = ID_WIDTH + PORT_BITS
) (
   input  logic                                  clk,
   input  logic                                  rst,

   input  logic [PORTS-1:0]                      req_in_valid,
   output logic [PORTS-1:0]                      req_in_ready,
   input  logic [PORTS-1:0]                      req_in_read_enable,
   input  logic [PORTS-1:0]                      req_in_write_enable,
   input  logic [PORTS-1:0][ADDR_WIDTH-1:0]      req_in_addr,
   input  logic [PORTS-1:0][DATA_WIDTH-1:0]      req_in_data,
   input  logic [PORTS-1:0]                      req_in_last,
   input  logic [PORTS-1:0][ID_WIDTH-1:0]        req_in_id,

   output logic                                  req_out_valid,
   input  logic                                  req_out_ready,
   output logic                                  req_out_read_enable,
   output logic                                  req_out_write_enable,
   output logic [ADDR_WIDTH-1:0]                 req_out_addr,
   output logic [DATA_WIDTH-1:0]                 req_out_data,
   output logic                                  req_out_last,
   output logic [OUT_ID_WIDTH-1:0]               req_out_id,

   input  logic                                  rsp_in_valid,
   output logic                                  rsp_in_ready,
   input  logic                                  rsp_in_read_enable,
   input  logic                                  rsp_in_write_enable,
   input  logic [ADDR_WIDTH-1:0]                 rsp_in_addr,
   input  logic [DATA_WIDTH-1:0]                 rsp_in_data,
   input  logic                                  rsp_in_last,
   input  logic [OUT_ID_WIDTH-1:0]               rsp_in_id,

   output logic [PORTS-1:0]                      rsp_out_valid,
   input  logic [PORTS-1:0]                      rsp_out_ready,
   output logic [PORTS-1:0]                      rsp_out_read_enable,
   output logic [PORTS-1:0]                      rsp_out_write_enable,
   output logic [PORTS-1:0][ADDR_WIDTH-1:0]      rsp_out_addr,
   output logic [PORTS-1:0][DATA_WIDTH-1:0]      rsp_out_data,
   output logic [PORTS-1:0]                      rsp_out_last,
   output logic [PORTS-1:0][ID_WIDTH-1:0]        rsp_out_id
);

   logic [PORT_BITS-1:0] rr_ptr;
   logic [PORT_BITS-1:0] lock_port;
   logic                 locked;
   logic [PORT_BITS-1:0] grant;
   logic                 have_grant;
   logic                 load_ok;
   logic                 accept;
   logic [PORT_BITS-1:0] rr_next;

   assign load_ok = !req_out_valid || req_out_ready;

   // While locked the holder keeps the grant even with valid low, so no
   // other requester can slip into the middle of a burst.
   always_comb begin
      int idx;
      idx        = 0;
      grant      = lock_port;
      have_grant = locked;
      if (!locked) begin
         grant      = '0;
         have_grant = 1'b0;
         for (int k = 0; k < PORTS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= PORTS) idx = idx - PORTS;
            if (!have_grant && req_in_valid[idx]) begin
               have_grant = 1'b1;
               grant      = PORT_BITS'(idx);
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < PORTS; i++) begin
         req_in_ready[i] = !rst && load_ok && have_grant && (int'(grant) == i);
      end
   end

   assign accept  = have_grant && req_in_valid[grant] && req_in_ready[grant];
   assign rr_next = (int'(grant) == PORTS - 1) ? '0 : grant + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         req_out_valid <= 1'b0;
         rr_ptr        <= '0;
         locked        <= 1'b0;
         lock_port     <= '0;
      end else begin
         if (load_ok) req_out_valid <= accept;
         if (accept) begin
            req_out_read_enable  <= req_in_read_enable[grant];
            req_out_write_enable <= req_in_write_enable[grant];
            req_out_addr         <= req_in_addr[grant];
            req_out_data         <= req_in_data[grant];
            req_out_last         <= req_in_last[grant];
            req_out_id           <= {grant, req_in_id[grant]};
            if (req_in_last[grant] || LOCK_ON_LAST == 0) rr_ptr <= rr_next;
            if (req_in_last[grant]) begin
               locked <= 1'b0;
            end else if (LOCK_ON_LAST != 0) begin
               locked    <= 1'b1;
               lock_port <= grant;
            end
         end
      end
   end

   logic [PORT_BITS-1:0] rsp_sel;
   logic                 sel_free;
   logic                 rsp_take;

   assign rsp_sel = rsp_in_id[OUT_ID_WIDTH-1:ID_WIDTH];

   // Ids naming a port that does not exist fall through with sel_free=1
   // and are dropped, so the response channel can never wedge on them.
   always_comb begin
      sel_free = 1'b1;
      for (int p = 0; p < PORTS; p++) begin
         if (int'(rsp_sel) == p) sel_free = !rsp_out_valid[p] || rsp_out_ready[p];
      end
   end

   assign rsp_in_ready = !rst && sel_free;
   assign rsp_take     = rsp_in_valid && rsp_in_ready;

   always_ff @(posedge clk) begin
      for (int p = 0; p < PORTS; p++) begin
         if (rst) begin
            rsp_out_valid[p] <= 1'b0;
         end else if (!rsp_out_valid[p] || rsp_out_ready[p]) begin
            rsp_out_valid[p] <= rsp_take && (int'(rsp_sel) == p);
            if (rsp_take && (int'(rsp_sel) == p)) begin
               rsp_out_read_enable[p]  <= rsp_in_read_enable;
               rsp_out_write_enable[p] <= rsp_in_write_enable;
               rsp_out_addr[p]         <= rsp_in_addr;
               rsp_out_data[p]         <= rsp_in_data;
               rsp_out_last[p]         <= rsp_in_last;
               rsp_out_id[p]           <= rsp_in_id[ID_WIDTH-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed self-checking bench for mem_request_arbiter (2 ports,
// lock on last). Inputs change 1ns after posedge; outputs read there too.
module tb_mem_request_arbiter;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        req_in_valid;
   logic [1:0]        req_in_ready;
   logic [1:0]        req_in_read_enable;
   logic [1:0]        req_in_write_enable;
   logic [1:0][9:0]   req_in_addr;
   logic [1:0][31:0]  req_in_data;
   logic [1:0]        req_in_last;
   logic [1:0][0:0]   req_in_id;
   logic              req_out_valid;
   logic              req_out_ready;
   logic              req_out_read_enable;
   logic              req_out_write_enable;
   logic [9:0]        req_out_addr;
   logic [31:0]       req_out_data;
   logic              req_out_last;
   logic [1:0]        req_out_id;
   logic              rsp_in_valid;
   logic              rsp_in_ready;
   logic              rsp_in_read_enable;
   logic              rsp_in_write_enable;
   logic [9:0]        rsp_in_addr;
   logic [31:0]       rsp_in_data;
   logic              rsp_in_last;
   logic [1:0]        rsp_in_id;
   logic [1:0]        rsp_out_valid;
   logic [1:0]        rsp_out_ready;
   logic [1:0]        rsp_out_read_enable;
   logic [1:0]        rsp_out_write_enable;
   logic [1:0][9:0]   rsp_out_addr;
   logic [1:0][31:0]  rsp_out_data;
   logic [1:0]        rsp_out_last;
   logic [1:0][0:0]   rsp_out_id;

   int checks = 0;
   int errors = 0;

   mem_request_arbiter #(
      .PORTS(2), .DATA_WIDTH(32), .ADDR_WIDTH(10),
      .ID_WIDTH(1), .LOCK_ON_LAST(1)
   ) dut (
      .clk(clk), .rst(rst),
      .req_in_valid(req_in_valid), .req_in_ready(req_in_ready),
      .req_in_read_enable(req_in_read_enable),
      .req_in_write_enable(req_in_write_enable),
      .req_in_addr(req_in_addr), .req_in_data(req_in_data),
      .req_in_last(req_in_last), .req_in_id(req_in_id),
      .req_out_valid(req_out_valid), .req_out_ready(req_out_ready),
      .req_out_read_enable(req_out_read_enable),
      .req_out_write_enable(req_out_write_enable),
      .req_out_addr(req_out_addr), .req_out_data(req_out_data),
      .req_out_last(req_out_last), .req_out_id(req_out_id),
      .rsp_in_valid(rsp_in_valid), .rsp_in_ready(rsp_in_ready),
      .rsp_in_read_enable(rsp_in_read_enable),
      .rsp_in_write_enable(rsp_in_write_enable),
      .rsp_in_addr(rsp_in_addr), .rsp_in_data(rsp_in_data),
      .rsp_in_last(rsp_in_last), .rsp_in_id(rsp_in_id),
      .rsp_out_valid(rsp_out_valid), .rsp_out_ready(rsp_out_ready),
      .rsp_out_read_enable(rsp_out_read_enable),
      .rsp_out_write_enable(rsp_out_write_enable),
      .rsp_out_addr(rsp_out_addr), .rsp_out_data(rsp_out_data),
      .rsp_out_last(rsp_out_last), .rsp_out_id(rsp_out_id)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_in_valid        = 2'b00;
      req_in_read_enable  = 2'b11;
      req_in_write_enable = 2'b00;
      req_in_addr         = '0;
      req_in_data         = '0;
      req_in_last         = 2'b11;
      req_in_id           = '0;
      req_out_ready       = 1'b1;
      rsp_in_valid        = 1'b0;
      rsp_in_read_enable  = 1'b1;
      rsp_in_write_enable = 1'b0;
      rsp_in_addr         = '0;
      rsp_in_data         = '0;
      rsp_in_last         = 1'b1;
      rsp_in_id           = '0;
      rsp_out_ready       = 2'b11;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      req_in_valid = 2'b11;
      rsp_in_valid = 1'b1;
      #1;
      checks++;
      if (req_in_ready !== 2'b00) begin
         errors++;
         $display("FAIL reset_req_ready: got %b expected 00", req_in_ready);
      end
      checks++;
      if (rsp_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_rsp_ready: got %b expected 0", rsp_in_ready);
      end
      step();
      step();
      rst = 1'b0;
      req_in_valid = 2'b00;
      rsp_in_valid = 1'b0;
      checks++;
      if (req_out_valid !== 1'b0 || rsp_out_valid !== 2'b00) begin
         errors++;
         $display("FAIL reset_valids: got %b/%b expected 0/00", req_out_valid, rsp_out_valid);
      end
   endtask

   task automatic test_single();
      do_reset();
      req_in_id[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         req_in_valid = 2'b10;
         req_in_addr[1] = 10'h10 + 10'(k);
         #1;
         checks++;
         if (req_in_ready !== 2'b10) begin
            errors++;
            $display("FAIL single_ready%0d: got %b expected 10", k, req_in_ready);
         end
         step();
         checks++;
         if (req_out_valid !== 1'b1 || req_out_addr !== 10'h10 + 10'(k) || req_out_id !== 2'd3) begin
            errors++;
            $display("FAIL single_beat%0d: got v%b a%h id%0d expected v1 a%h id3",
                     k, req_out_valid, req_out_addr, req_out_id, 10'h10 + 10'(k));
         end
      end
      req_in_valid = 2'b00;
      step();
      checks++;
      if (req_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_drain: got %b expected 0", req_out_valid);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      req_in_valid = 2'b11;
      req_in_addr[0] = 10'h20;
      req_in_addr[1] = 10'h30;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (req_in_ready !== 2'(1 << (k % 2))) begin
            errors++;
            $display("FAIL rr_ready%0d: got %b expected %b", k, req_in_ready, 2'(1 << (k % 2)));
         end
         step();
         checks++;
         if (req_out_valid !== 1'b1 || req_out_id[1] !== 1'(k % 2) ||
             req_out_addr !== ((k % 2 == 0) ? 10'h20 : 10'h30)) begin
            errors++;
            $display("FAIL rr_grant%0d: got v%b port%0d a%h expected port%0d",
                     k, req_out_valid, req_out_id[1], req_out_addr, k % 2);
         end
      end
      req_in_valid = 2'b00;
   endtask

   task automatic test_burst_lock();
      logic [3:0] p0v;
      logic [3:0] p0l;
      p0v = 4'b1011;
      p0l = 4'b1000;
      do_reset();
      req_in_addr[1] = 10'h40;
      for (int k = 0; k < 4; k++) begin
         req_in_valid = {1'b1, p0v[k]};
         req_in_last[0] = p0l[k];
         req_in_addr[0] = 10'h50 + 10'((k > 2) ? 2 : k);
         #1;
         checks++;
         if (req_in_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL lock_block%0d: got %b expected 0", k, req_in_ready[1]);
         end
         step();
         if (p0v[k]) begin
            checks++;
            if (req_out_valid !== 1'b1 || req_out_id[1] !== 1'b0 ||
                req_out_last !== p0l[k]) begin
               errors++;
               $display("FAIL lock_beat%0d: got v%b port%0d l%b expected v1 port0 l%b",
                        k, req_out_valid, req_out_id[1], req_out_last, p0l[k]);
            end
         end
      end
      req_in_valid = 2'b10;
      #1;
      checks++;
      if (req_in_ready !== 2'b10) begin
         errors++;
         $display("FAIL lock_release: got %b expected 10", req_in_ready);
      end
      step();
      req_in_valid = 2'b00;
      checks++;
      if (req_out_valid !== 1'b1 || req_out_addr !== 10'h40 || req_out_id[1] !== 1'b1) begin
         errors++;
         $display("FAIL lock_next: got v%b a%h port%0d expected v1 a040 port1",
                  req_out_valid, req_out_addr, req_out_id[1]);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      req_out_ready = 1'b0;
      req_in_valid = 2'b01;
      req_in_addr[0] = 10'h60;
      req_in_data[0] = 32'hCAFE0060;
      step();
      req_in_addr[0] = 10'h61;
      req_in_data[0] = 32'hCAFE0061;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (req_in_ready !== 2'b00 || req_out_valid !== 1'b1 ||
             req_out_addr !== 10'h60 || req_out_data !== 32'hCAFE0060) begin
            errors++;
            $display("FAIL bp_hold%0d: got r%b v%b a%h d%h expected r00 v1 a060 dcafe0060",
                     k, req_in_ready, req_out_valid, req_out_addr, req_out_data);
         end
         step();
      end
      req_out_ready = 1'b1;
      #1;
      checks++;
      if (req_in_ready !== 2'b01) begin
         errors++;
         $display("FAIL bp_release: got %b expected 01", req_in_ready);
      end
      step();
      req_in_valid = 2'b00;
      checks++;
      if (req_out_valid !== 1'b1 || req_out_addr !== 10'h61) begin
         errors++;
         $display("FAIL bp_next: got v%b a%h expected v1 a061", req_out_valid, req_out_addr);
      end
      step();
      checks++;
      if (req_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_empty: got %b expected 0", req_out_valid);
      end
   endtask

   task automatic test_response();
      do_reset();
      rsp_out_ready = 2'b01;
      rsp_in_valid = 1'b1;
      rsp_in_id = 2'b01;
      rsp_in_data = 32'hAAAA0001;
      #1;
      checks++;
      if (rsp_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rsp_a_ready: got %b expected 1", rsp_in_ready);
      end
      step();
      checks++;
      if (rsp_out_valid !== 2'b01 || rsp_out_data[0] !== 32'hAAAA0001 || rsp_out_id[0] !== 1'b1) begin
         errors++;
         $display("FAIL rsp_a: got v%b d%h id%b expected v01 daaaa0001 id1",
                  rsp_out_valid, rsp_out_data[0], rsp_out_id[0]);
      end
      rsp_in_id = 2'b10;
      rsp_in_data = 32'hBBBB0002;
      step();
      checks++;
      if (rsp_out_valid !== 2'b10 || rsp_out_data[1] !== 32'hBBBB0002 || rsp_out_id[1] !== 1'b0) begin
         errors++;
         $display("FAIL rsp_b: got v%b d%h id%b expected v10 dbbbb0002 id0",
                  rsp_out_valid, rsp_out_data[1], rsp_out_id[1]);
      end
      rsp_in_id = 2'b11;
      rsp_in_data = 32'hCCCC0003;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (rsp_in_ready !== 1'b0 || rsp_out_data[1] !== 32'hBBBB0002) begin
            errors++;
            $display("FAIL rsp_stall%0d: got r%b d%h expected r0 dbbbb0002",
                     k, rsp_in_ready, rsp_out_data[1]);
         end
         step();
      end
      rsp_out_ready = 2'b11;
      #1;
      checks++;
      if (rsp_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rsp_c_ready: got %b expected 1", rsp_in_ready);
      end
      step();
      rsp_in_valid = 1'b0;
      checks++;
      if (rsp_out_valid !== 2'b10 || rsp_out_data[1] !== 32'hCCCC0003 || rsp_out_id[1] !== 1'b1) begin
         errors++;
         $display("FAIL rsp_c: got v%b d%h id%b expected v10 dcccc0003 id1",
                  rsp_out_valid, rsp_out_data[1], rsp_out_id[1]);
      end
      step();
      checks++;
      if (rsp_out_valid !== 2'b00) begin
         errors++;
         $display("FAIL rsp_drain: got %b expected 00", rsp_out_valid);
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      req_in_valid = 2'b01;
      req_in_addr[0] = 10'h70;
      step();
      req_in_valid = 2'b11;
      req_in_addr[0] = 10'h71;
      req_in_addr[1] = 10'h80;
      req_in_last[1] = 1'b0;
      #1;
      checks++;
      if (req_in_ready !== 2'b10) begin
         errors++;
         $display("FAIL mid_grant1: got %b expected 10", req_in_ready);
      end
      step();
      req_in_addr[1] = 10'h81;
      rst = 1'b1;
      #1;
      checks++;
      if (req_in_ready !== 2'b00) begin
         errors++;
         $display("FAIL mid_rst_ready: got %b expected 00", req_in_ready);
      end
      step();
      rst = 1'b0;
      checks++;
      if (req_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_stale: got %b expected 0", req_out_valid);
      end
      #1;
      checks++;
      if (req_in_ready !== 2'b01) begin
         errors++;
         $display("FAIL mid_fresh: got %b expected 01", req_in_ready);
      end
      step();
      req_in_valid = 2'b00;
      checks++;
      if (req_out_valid !== 1'b1 || req_out_addr !== 10'h71 || req_out_id[1] !== 1'b0) begin
         errors++;
         $display("FAIL mid_port0: got v%b a%h port%0d expected v1 a071 port0",
                  req_out_valid, req_out_addr, req_out_id[1]);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_single();
      test_round_robin();
      test_burst_lock();
      test_backpressure();
      test_response();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
